hls_wdma: RTL and testbench

HLS_WDMA -- requirements
Module: hls_wdma

---
 rtl/hls_dma_pkg.sv | 18 +
 rtl/hls_wdma_if.sv | 35 +++
 rtl/hls_wdma_fifo.sv | 49 ++++
 rtl/hls_wdma.sv | 142 ++++++++++++++
 tb/tb_hls_wdma.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/hls_dma_pkg.sv
// Shared types and constants for the stream-to-AXI write DMA.
package hls_dma_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int AXI_LEN_WIDTH = 8;
  localparam int AXI_BURST_LIMIT = 256;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/hls_wdma_if.sv
// Stream input plus AXI write channels of the DMA; master is the DMA side.
interface hls_wdma_if
  import hls_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0]    s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [ADDR_WIDTH-1:0]    m_axi_awaddr;
  logic [AXI_LEN_WIDTH-1:0] m_axi_awlen;
  logic                     m_axi_awvalid;
  logic                     m_axi_awready;
  logic [DATA_WIDTH-1:0]    m_axi_wdata;
  logic [DATA_WIDTH/8-1:0]  m_axi_wstrb;
  logic                     m_axi_wlast;
  logic                     m_axi_wvalid;
  logic                     m_axi_wready;
  logic [1:0]               m_axi_bresp;
  logic                     m_axi_bvalid;
  logic                     m_axi_bready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output s_axis_tready, m_axi_awaddr, m_axi_awlen, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
           m_axi_wlast, m_axi_wvalid, m_axi_bready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input  s_axis_tready, m_axi_awaddr, m_axi_awlen, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
           m_axi_wlast, m_axi_wvalid, m_axi_bready
  );
endinterface

// File: rtl/hls_wdma_fifo.sv
// Staging FIFO with occupancy count; simultaneous push and pop keep count unchanged.
module hls_wdma_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/hls_wdma.sv
// Stream-to-DRAM write DMA: stages words in a FIFO and issues full AXI bursts.
// Optional HLS_WDMA_ERR_EN adds a sticky ap_err flag for non-OKAY write responses.
module hls_wdma
  import hls_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len_words,
`ifdef HLS_WDMA_ERR_EN
  output logic                  ap_err,
`endif
  hls_wdma_if.master            bus
);
  // states: IDLE wait start | AW await burst data, issue addr | W send beats | B await resp | DONE pulse done
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q, remaining, accepted, beat_cnt, beats;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full, busy, push, aw_fire, w_fire, b_fire, last_beat;
  logic                  awvalid, wvalid, bready;

  assign beats     = (remaining > LEN_WIDTH'(MAX_BURST)) ? LEN_WIDTH'(MAX_BURST) : remaining;
  assign busy      = (state == ST_AW) || (state == ST_W) || (state == ST_B);
  assign last_beat = (beat_cnt == beats - 1'b1);

  assign bus.s_axis_tready = busy && !fifo_full && (accepted < len_q);
  assign push    = bus.s_axis_tvalid && bus.s_axis_tready;
  assign aw_fire = awvalid && bus.m_axi_awready;
  assign w_fire  = wvalid && bus.m_axi_wready;
  assign b_fire  = bready && bus.m_axi_bvalid;

  // Address fields are zeroed when not presented so the bus is quiet outside a request.
  assign bus.m_axi_awvalid = awvalid;
  assign bus.m_axi_awaddr  = awvalid ? addr_q : '0;
  assign bus.m_axi_awlen   = awvalid ? AXI_LEN_WIDTH'(beats - 1'b1) : '0;
  assign bus.m_axi_wvalid  = wvalid;
  assign bus.m_axi_wdata   = wvalid ? fifo_dout : '0;
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wlast   = wvalid && last_beat;
  assign bus.m_axi_bready  = bready;

  hls_wdma_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .push  (push),
    .din   (bus.s_axis_tdata),
    .pop   (w_fire),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    ap_ready  = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state)
      ST_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_nxt = (len_words == '0) ? ST_DONE : ST_AW;
      end
      ST_AW: begin
        awvalid = (32'(fifo_count) >= 32'(beats));
        if (aw_fire) state_nxt = ST_W;
      end
      ST_W: begin
        wvalid = 1'b1;
        if (w_fire && last_beat) state_nxt = ST_B;
      end
      ST_B: begin
        bready = 1'b1;
        if (bus.m_axi_bvalid) state_nxt = (remaining == beats) ? ST_DONE : ST_AW;
      end
      ST_DONE: begin
        ap_done   = 1'b1;
        ap_ready  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      remaining <= '0;
      accepted  <= '0;
      beat_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && ap_start) begin
        addr_q    <= base_addr;
        len_q     <= len_words;
        remaining <= len_words;
        accepted  <= '0;
      end
      if (push) accepted <= accepted + 1'b1;
      if (aw_fire) begin
        addr_q   <= addr_q + ADDR_WIDTH'(beats) * ADDR_WIDTH'(BYTES);
        beat_cnt <= '0;
      end
      if (w_fire) beat_cnt <= beat_cnt + 1'b1;
      if (b_fire) remaining <= remaining - beats;
    end
  end

`ifdef HLS_WDMA_ERR_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ap_err <= 1'b0;
    end else if (state == ST_IDLE && ap_start) begin
      ap_err <= 1'b0;
    end else if (b_fire && bus.m_axi_bresp != AXI_RESP_OKAY) begin
      ap_err <= 1'b1;
    end
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^bus.m_axi_bresp;
`endif
endmodule

// File: tb/tb_hls_wdma.sv
// Randomized bench for hls_wdma: a queue-based model predicts bursts, beats and data per transfer.
module tb_hls_wdma;
  import hls_dma_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int MB = 16;
  localparam int FD = 32;

  logic          ap_clk = 1'b0;
  logic          ap_rst, ap_start, ap_done, ap_idle, ap_ready;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len_words;
`ifdef HLS_WDMA_ERR_EN
  logic          ap_err;
`endif

  hls_wdma_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  hls_wdma #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_BURST(MB), .FIFO_DEPTH(FD)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .ap_done   (ap_done),
    .ap_idle   (ap_idle),
    .ap_ready  (ap_ready),
    .base_addr (base_addr),
    .len_words (len_words),
`ifdef HLS_WDMA_ERR_EN
    .ap_err    (ap_err),
`endif
    .bus       (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks, n_fail;
  logic [DW-1:0] src_q[$], acc_q[$], wd_q[$];
  logic          wl_q[$];
  logic [AW-1:0] aa_q[$];
  logic [7:0]    al_q[$];
  int occ, b_pending, b_cnt, err_burst, cur_len;
  int gap_pct, aw_stall, w_stall;
  logic          start_req, rst_req;
  logic [AW-1:0] start_base;
  logic [LW-1:0] start_len;
  bit            done_seen;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, then record what the next rising edge will accept.
  task automatic step();
    @(negedge ap_clk);
    ap_rst    = rst_req;
    ap_start  = start_req;
    base_addr = start_base;
    len_words = start_len;
    start_req = 1'b0;
    bus.s_axis_tvalid = (src_q.size() > 0) && (int'($urandom_range(99)) >= gap_pct);
    bus.s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
    bus.m_axi_awready = int'($urandom_range(99)) >= aw_stall;
    bus.m_axi_wready  = int'($urandom_range(99)) >= w_stall;
    bus.m_axi_bvalid  = (b_pending > 0) && ($urandom_range(1) == 1);
    bus.m_axi_bresp   = (b_cnt == err_burst) ? 2'b10 : AXI_RESP_OKAY;
    #1;
    if (ap_rst) begin
      occ = 0;
      b_pending = 0;
      return;
    end
    if (bus.s_axis_tready) check_eq("tready_limit", acc_q.size() < cur_len, 1);
    if (bus.m_axi_wvalid) begin
      check_eq("wvalid_fifo_empty", occ > 0, 1);
      if (bus.m_axi_wready) begin
        check_eq("wstrb", bus.m_axi_wstrb, 4'hF);
        wd_q.push_back(bus.m_axi_wdata);
        wl_q.push_back(bus.m_axi_wlast);
        occ--;
        if (bus.m_axi_wlast) b_pending++;
      end
    end
    if (bus.s_axis_tvalid && bus.s_axis_tready) begin
      acc_q.push_back(src_q.pop_front());
      occ++;
    end
    if (bus.m_axi_awvalid && bus.m_axi_awready) begin
      aa_q.push_back(bus.m_axi_awaddr);
      al_q.push_back(bus.m_axi_awlen);
    end
    if (bus.m_axi_bvalid && bus.m_axi_bready) begin
      b_pending--;
      b_cnt++;
    end
    if (ap_done) begin
      done_seen = 1'b1;
      check_eq("ready_with_done", ap_ready, 1);
    end
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_idle"},    ap_idle, 1);
    check_eq({tag, "_done"},    ap_done, 0);
    check_eq({tag, "_ready"},   ap_ready, 0);
    check_eq({tag, "_tready"},  bus.s_axis_tready, 0);
    check_eq({tag, "_awvalid"}, bus.m_axi_awvalid, 0);
    check_eq({tag, "_wvalid"},  bus.m_axi_wvalid, 0);
    check_eq({tag, "_wlast"},   bus.m_axi_wlast, 0);
    check_eq({tag, "_bready"},  bus.m_axi_bready, 0);
    check_eq({tag, "_awaddr"},  bus.m_axi_awaddr, 0);
    check_eq({tag, "_awlen"},   bus.m_axi_awlen, 0);
    check_eq({tag, "_wdata"},   bus.m_axi_wdata, 0);
`ifdef HLS_WDMA_ERR_EN
    check_eq({tag, "_err"},     ap_err, 0);
`endif
  endtask

  task automatic run_transfer(input logic [AW-1:0] base, input int len, input int offered,
                              input int gap, input int aws, input int ws, input int errb,
                              input int abort_at);
    logic [DW-1:0] exp_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [7:0]    exp_len[$];
    logic          exp_last[$];
    logic [AW-1:0] a;
    int rem, nb;
    src_q.delete(); acc_q.delete(); wd_q.delete(); wl_q.delete(); aa_q.delete(); al_q.delete();
    occ = 0; b_pending = 0; b_cnt = 0; done_seen = 1'b0;
    for (int i = 0; i < offered; i++) src_q.push_back($urandom);
    for (int i = 0; i < len; i++) exp_data.push_back(src_q[i]);
    // Expected burst split: MB-beat bursts, remainder last.
    rem = len; a = base;
    while (rem > 0) begin
      nb = (rem > MB) ? MB : rem;
      exp_addr.push_back(a);
      exp_len.push_back(8'(nb - 1));
      for (int j = 0; j < nb; j++) exp_last.push_back(j == nb - 1);
      a = a + AW'(nb * (DW / 8));
      rem = rem - nb;
    end
    gap_pct = gap; aw_stall = aws; w_stall = ws; err_burst = errb; cur_len = len;
    check_eq("idle_before_start", ap_idle, 1);
    start_base = base; start_len = LW'(len); start_req = 1'b1;
    step();
    step();
    if (len == 0) check_eq("zero_len_done_cycle2", ap_done, 1);
    else          check_eq("busy_not_idle", ap_idle, 0);
`ifdef HLS_WDMA_ERR_EN
    check_eq("err_cleared_on_start", ap_err, 0);
`endif
    for (int k = 0; k < 3000 && !done_seen; k++) begin
      if (abort_at > 0 && wd_q.size() == abort_at) begin
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        reset_checks("midw_rst");
        check_eq("midw_no_done", done_seen, 0);
        return;
      end
      step();
    end
    if (!done_seen) begin
      check_eq("done_timeout", 0, 1);
      return;
    end
`ifdef HLS_WDMA_ERR_EN
    check_eq("ap_err_at_done", ap_err, (errb >= 0) ? 1 : 0);
`endif
    check_eq("aw_count", aa_q.size(), exp_addr.size());
    for (int i = 0; i < aa_q.size() && i < exp_addr.size(); i++) begin
      check_eq("awaddr", aa_q[i], exp_addr[i]);
      check_eq("awlen", al_q[i], exp_len[i]);
    end
    check_eq("w_count", wd_q.size(), len);
    for (int i = 0; i < wd_q.size() && i < len; i++) begin
      check_eq("wdata", wd_q[i], exp_data[i]);
      check_eq("wlast", wl_q[i], exp_last[i]);
    end
    check_eq("accepted", acc_q.size(), len);
    check_eq("b_count", b_cnt, exp_addr.size());
    check_eq("stream_left", src_q.size(), offered - len);
    step();
    check_eq("done_single_pulse", ap_done, 0);
    check_eq("idle_after_done", ap_idle, 1);
    check_eq("tready_after_done", bus.s_axis_tready, 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    ap_rst = 1'b1; rst_req = 1'b1; ap_start = 1'b0; start_req = 1'b0;
    start_base = '0; start_len = '0; base_addr = '0; len_words = '0;
    gap_pct = 0; aw_stall = 0; w_stall = 0; err_burst = -1; cur_len = 0;
    occ = 0; b_pending = 0; b_cnt = 0; done_seen = 1'b0;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
    repeat (3) step();
    rst_req = 1'b0;
    step();
    reset_checks("por");

    run_transfer(32'h0000, 0, 0, 0, 0, 0, -1, 0);
    run_transfer(32'h1000, 40, 40, 0, 0, 0, -1, 0);
    run_transfer(32'h2000, 20, 20, 30, 40, 40, -1, 0);
    run_transfer(32'h3000, 40, 40, 10, 10, 10, 0, 0);
    run_transfer(32'h4000, 4, 4, 0, 0, 0, -1, 0);
    run_transfer(32'h5000, 20, 20, 0, 0, 0, -1, 5);
    run_transfer(32'h6000, 4, 4, 0, 0, 0, -1, 0);
    run_transfer(32'h7000, 16, 50, 20, 0, 0, -1, 0);
    for (int t = 0; t < 4; t++) begin
      int l;
      l = int'($urandom_range(45, 1));
      run_transfer(AW'($urandom_range(1023)) << 6, l, l + int'($urandom_range(5)),
                   25, 25, 25, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
